sr_cmd_sequencer: RTL
=====================

SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 4, giving command FIFO entries; the value SHALL be a power of 2 and at least 2.
REQ-002 The block SHALL have the parameter DW, default 4, giving the dwell counter width.
REQ-003 The block SHALL have the port CLK, input, width 1: the single clock, with all state on the rising edge.
REQ-004 The block SHALL have the port RST, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have the port CMD_VALID, input, width 1: command offered.
REQ-006 The block SHALL have the port CMD_READY, output, width 1: FIFO can accept.
REQ-007 The block SHALL have the port CMD_OP, input, width 2: the command opcode, encoded 00 HOLD, 01 SET, 10 RESET, 11 LOAD.
REQ-008 The block SHALL have the port CMD_DATA, input, width 1: the D value for LOAD, ignored otherwise.
REQ-009 The block SHALL have the port CMD_DWELL, input, width DW: extra cycles the encoding is held.
REQ-010 The block SHALL have the port SET_B, output, width 1: active-low set to the downstream SR flop.
REQ-011 The block SHALL have the port RESET_B, output, width 1: active-low reset to the downstream SR flop.
REQ-012 The block SHALL have the port D, output, width 1: data to the downstream SR flop.
REQ-013 The block SHALL have the port Q_FB, input, width 1: the downstream flop Q, fed back.
REQ-014 The block SHALL have the port EXP_Q, output, width 1: the expected Q after the last popped command.
REQ-015 The block SHALL have the port MISMATCH, output, width 1: sticky flag set when Q_FB != EXP_Q at check.
REQ-016 The block SHALL have the port CLR_ERR, input, width 1: synchronous clear of MISMATCH.
REQ-017 The block SHALL have the port BUSY, output, width 1: high when the FSM is not in IDLE.
REQ-018 The block SHALL have the port COUNT, output, width log2(DEPTH)+1: FIFO occupancy.

Function
REQ-019 CMD_READY SHALL equal !full, combinationally; a push SHALL occur on an edge with CMD_VALID && CMD_READY, storing {OP, DATA, DWELL}.
REQ-020 The FSM SHALL have the states IDLE, APPLY and CHECK; its outputs SET_B, RESET_B, D, EXP_Q and MISMATCH SHALL be registered.
REQ-021 IDLE and FIFO non-empty SHALL pop the head on the next edge, go to APPLY, load the dwell counter with DWELL, and register the encoding.
REQ-022 A pushed command SHALL reach the outputs no earlier than 2 edges after acceptance; pop and push SHALL never coincide on an empty FIFO.
REQ-023 The encoding SHALL be: SET gives SET_B=0, RESET_B=1; RESET gives SET_B=1, RESET_B=0; LOAD gives SET_B=0, RESET_B=0, D=CMD_DATA; HOLD gives SET_B=1, RESET_B=1.
REQ-024 On a HOLD or a SET/RESET pop, D SHALL keep its value.
REQ-025 EXP_Q SHALL update on the pop edge: SET gives 1, RESET gives 0, LOAD gives DATA, HOLD gives unchanged.
REQ-026 In APPLY, a counter of 0 on the edge SHALL force SET_B=1, RESET_B=1 and go to CHECK; otherwise the counter SHALL decrement.
REQ-027 The encoding SHALL therefore be visible for exactly DWELL+1 cycles.
REQ-028 The CHECK state SHALL last exactly one cycle; on its exit edge, Q_FB != EXP_Q SHALL set MISMATCH, and the FSM SHALL go to IDLE.
REQ-029 The next command SHALL pop at the earliest on the edge after return to IDLE, giving a minimum of DWELL+3 cycles per command.
REQ-030 If a MISMATCH set and CLR_ERR coincide, MISMATCH SHALL end high (set wins).
REQ-031 On a full FIFO, CMD_READY SHALL be 0 and CMD_VALID SHALL be ignored, with no overwrite.
REQ-032 A simultaneous push and pop SHALL leave COUNT unchanged.
REQ-033 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-034 BUSY SHALL be 1 in APPLY and CHECK.

Reset
REQ-035 While RST=1, independent of CLK: the FIFO SHALL be emptied (COUNT=0), the state SHALL be IDLE, SET_B=1, RESET_B=1, D=0, EXP_Q=0, MISMATCH=0 and BUSY=0.
REQ-036 CMD_READY SHALL be 1 during and after reset.
REQ-037 A reset asserted during APPLY or CHECK SHALL abort the command immediately, return SET_B and RESET_B to 1, and discard all queued commands.
REQ-038 After RST falls, the first push SHALL be accepted on the first rising edge.

Verification
REQ-039 Push SET with DWELL=2 -> SET_B=0 for 3 cycles starting 2 edges after accept; EXP_Q=1; with a model flop, MISMATCH stays 0; BUSY is high for 4 cycles.
REQ-040 Push LOAD DATA=1 DWELL=0, then LOAD DATA=0 DWELL=0 -> SET_B=RESET_B=0 for one cycle each, D=1 then D=0, EXP_Q 1 then 0, and the two commands are separated by 2 idle-encoding cycles.
REQ-041 Fill 4 commands with no pops (hold Q_FB model) -> COUNT=4 and CMD_READY=0, a fifth CMD_VALID is dropped, and the commands are later applied in order.
REQ-042 Push RESET with Q_FB forced to 1 -> MISMATCH=1 on the CHECK exit edge; CLR_ERR asserted on that same edge leaves MISMATCH=1, and asserted on the next edge clears it to 0.
REQ-043 Assert RST mid-APPLY of SET with DWELL=7 and 2 commands queued -> SET_B=RESET_B=1 immediately, COUNT=0, BUSY=0, EXP_Q=0, and a post-reset push is processed normally.
REQ-044 Push HOLD with DWELL=1 -> SET_B=RESET_B=1 throughout, EXP_Q unchanged, and BUSY high for 3 cycles.

Source files
------------

// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for a downstream active-low SR/load flop: queues opcodes,
// drives SET_B/RESET_B/D for a programmable dwell, then checks the fed-back Q.
module sr_cmd_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       CMD_VALID,
   output logic                       CMD_READY,
   input  logic [1:0]                 CMD_OP,
   input  logic                       CMD_DATA,
   input  logic [DW-1:0]              CMD_DWELL,
   output logic                       SET_B,
   output logic                       RESET_B,
   output logic                       D,
   input  logic                       Q_FB,
   output logic                       EXP_Q,
   output logic                       MISMATCH,
   input  logic                       CLR_ERR,
   output logic                       BUSY,
   output logic [$clog2(DEPTH):0]     COUNT
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [1:0] OP_HOLD  = 2'b00;
   localparam logic [1:0] OP_SET   = 2'b01;
   localparam logic [1:0] OP_RESET = 2'b10;
   localparam logic [1:0] OP_LOAD  = 2'b11;

   typedef struct packed {
      logic [1:0]    op;
      logic          data;
      logic [DW-1:0] dwell;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   cmd_t            mem_q [DEPTH];
   cmd_t            mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   state_t          state_q, state_d;
   logic [DW-1:0]   cnt_q, cnt_d;
   logic            set_b_q, set_b_d;
   logic            reset_b_q, reset_b_d;
   logic            d_q, d_d;
   logic            exp_q_q, exp_q_d;
   logic            mismatch_q, mismatch_d;
   logic            busy_q, busy_d;

   logic            full;
   logic            push;
   logic            pop;
   cmd_t            head;
   cmd_t            cmd_in;

   assign full      = (count_q == CW'(DEPTH));
   assign CMD_READY = !full;
   assign push      = CMD_VALID && !full;
   assign head      = mem_q[rd_ptr_q];
   assign cmd_in    = '{op: CMD_OP, data: CMD_DATA, dwell: CMD_DWELL};

   // FIFO storage and pointers; pops only ever read a registered entry
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = cmd_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // Sequencing FSM; CLR_ERR is applied first so a same-edge mismatch wins
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      set_b_d    = set_b_q;
      reset_b_d  = reset_b_q;
      d_d        = d_q;
      exp_q_d    = exp_q_q;
      mismatch_d = mismatch_q;
      pop        = 1'b0;

      if (CLR_ERR) begin
         mismatch_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = ST_APPLY;
               cnt_d   = head.dwell;
               case (head.op)
                  OP_SET: begin
                     set_b_d   = 1'b0;
                     reset_b_d = 1'b1;
                     exp_q_d   = 1'b1;
                  end
                  OP_RESET: begin
                     set_b_d   = 1'b1;
                     reset_b_d = 1'b0;
                     exp_q_d   = 1'b0;
                  end
                  OP_LOAD: begin
                     set_b_d   = 1'b0;
                     reset_b_d = 1'b0;
                     d_d       = head.data;
                     exp_q_d   = head.data;
                  end
                  default: begin
                     set_b_d   = 1'b1;
                     reset_b_d = 1'b1;
                  end
               endcase
            end
         end
         ST_APPLY: begin
            if (cnt_q == '0) begin
               set_b_d   = 1'b1;
               reset_b_d = 1'b1;
               state_d   = ST_CHECK;
            end else begin
               cnt_d = cnt_q - DW'(1);
            end
         end
         ST_CHECK: begin
            if (Q_FB != exp_q_q) begin
               mismatch_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         set_b_q    <= 1'b1;
         reset_b_q  <= 1'b1;
         d_q        <= 1'b0;
         exp_q_q    <= 1'b0;
         mismatch_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         set_b_q    <= set_b_d;
         reset_b_q  <= reset_b_d;
         d_q        <= d_d;
         exp_q_q    <= exp_q_d;
         mismatch_q <= mismatch_d;
         busy_q     <= busy_d;
      end
   end

   assign SET_B    = set_b_q;
   assign RESET_B  = reset_b_q;
   assign D        = d_q;
   assign EXP_Q    = exp_q_q;
   assign MISMATCH = mismatch_q;
   assign BUSY     = busy_q;
   assign COUNT    = count_q;

endmodule
